// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control interface: control words, op/cond codes,
// FSM encoding, flag indices and the branch-condition evaluator.
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   localparam int FLG_Z = 0;
   localparam int FLG_S = 1;
   localparam int FLG_C = 2;

   // Control word: [4]=invert B, [3]=shift right, [2]=carry-in/arith shift, [1:0]=unit select
   localparam logic [4:0] ALUC_ADD = 5'b00000;
   localparam logic [4:0] ALUC_SUB = 5'b10100;
   localparam logic [4:0] ALUC_AND = 5'b00001;
   localparam logic [4:0] ALUC_XOR = 5'b00010;
   localparam logic [4:0] ALUC_SLL = 5'b00011;
   localparam logic [4:0] ALUC_SRL = 5'b01011;
   localparam logic [4:0] ALUC_SRA = 5'b01111;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;
   localparam logic [3:0] OP_SRL = 4'd5;
   localparam logic [3:0] OP_SRA = 4'd6;

   localparam logic [2:0] COND_NEVER  = 3'b000;
   localparam logic [2:0] COND_Z      = 3'b001;
   localparam logic [2:0] COND_NZ     = 3'b010;
   localparam logic [2:0] COND_S      = 3'b011;
   localparam logic [2:0] COND_GT     = 3'b100;
   localparam logic [2:0] COND_C      = 3'b101;
   localparam logic [2:0] COND_NC     = 3'b110;
   localparam logic [2:0] COND_ALWAYS = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
      logic r;
      r = 1'b0;
      case (c)
         COND_NEVER:  r = 1'b0;
         COND_Z:      r = f[FLG_Z];
         COND_NZ:     r = !f[FLG_Z];
         COND_S:      r = f[FLG_S];
         COND_GT:     r = !f[FLG_S] && !f[FLG_Z];
         COND_C:      r = f[FLG_C];
         COND_NC:     r = !f[FLG_C];
         COND_ALWAYS: r = 1'b1;
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decoder: operation code to ALU control word plus class bits.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [3:0] op,
   output logic [4:0] alu_ctrl,
   output logic       legal,
   output logic       is_arith,
   output logic       is_shift
);

   always_comb begin
      alu_ctrl = 5'b00000;
      legal    = 1'b1;
      is_arith = 1'b0;
      is_shift = 1'b0;
      case (op)
         OP_ADD: begin alu_ctrl = ALUC_ADD; is_arith = 1'b1; end
         OP_SUB: begin alu_ctrl = ALUC_SUB; is_arith = 1'b1; end
         OP_AND: alu_ctrl = ALUC_AND;
         OP_XOR: alu_ctrl = ALUC_XOR;
         OP_SLL: begin alu_ctrl = ALUC_SLL; is_shift = 1'b1; end
         OP_SRL: begin alu_ctrl = ALUC_SRL; is_shift = 1'b1; end
         OP_SRA: begin alu_ctrl = ALUC_SRA; is_shift = 1'b1; end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU control interface: issues one decoded op, captures
// result/flags one cycle later (carry is registered inside the ALU) and evaluates a branch.
module alu_op_sequencer
   import alu_pkg::*;
(
   input  logic              clka,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [2:0]        cond,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic              zero_flag,
   output logic              sign_flag,
   output logic              carry_flag,
   output logic              branch_taken,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [4:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [2:0]        alu_flags
);

   state_t            state_reg, state_next;
   logic [4:0]        dec_ctrl;
   logic              dec_legal, dec_arith, dec_shift;
   logic              accept;
   logic [DATA_W-1:0] b_eff;
   logic [2:0]        cond_reg;
   logic              arith_reg, err_reg, branch_reg;
   logic [DATA_W-1:0] result_reg, alu_a_reg, alu_b_reg;
   logic [4:0]        alu_ctrl_reg;
   logic [2:0]        flags_reg, flags_next;

   alu_op_decode u_decode (
      .op       (op),
      .alu_ctrl (dec_ctrl),
      .legal    (dec_legal),
      .is_arith (dec_arith),
      .is_shift (dec_shift)
   );

   // Shifts only see the shift-amount bits of B; upper bits are forced to zero.
   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bmask
         if (gi < SHAMT_W) begin : g_keep
            assign b_eff[gi] = b[gi];
         end else begin : g_mask
            assign b_eff[gi] = b[gi] & ~dec_shift;
         end
      end
   endgenerate

   always_ff @(posedge clka or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (start) state_next = dec_legal ? ST_ISSUE : ST_DONE;
         ST_ISSUE:   state_next = ST_CAPTURE;
         ST_CAPTURE: state_next = ST_DONE;
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_reg == ST_IDLE);
      done  = (state_reg == ST_DONE);
      err   = (state_reg == ST_DONE) && err_reg;
   end

   assign accept     = ready && start;
   // Only ADD/SUB refresh the stored flags; everything else keeps the previous set.
   assign flags_next = arith_reg ? alu_flags : flags_reg;

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         cond_reg     <= 3'b000;
         arith_reg    <= 1'b0;
         err_reg      <= 1'b0;
         result_reg   <= '0;
         flags_reg    <= 3'b000;
         branch_reg   <= 1'b0;
         alu_a_reg    <= '0;
         alu_b_reg    <= '0;
         alu_ctrl_reg <= 5'b00000;
      end else if (accept) begin
         cond_reg  <= cond;
         arith_reg <= dec_arith;
         err_reg   <= !dec_legal;
         if (dec_legal) begin
            alu_a_reg    <= a;
            alu_b_reg    <= b_eff;
            alu_ctrl_reg <= dec_ctrl;
         end else begin
            result_reg <= '0;
            branch_reg <= 1'b0;
         end
      end else if (state_reg == ST_CAPTURE) begin
         result_reg <= alu_res;
         flags_reg  <= flags_next;
         branch_reg <= cond_eval(cond_reg, flags_next);
      end
   end

   assign result       = result_reg;
   assign zero_flag    = flags_reg[FLG_Z];
   assign sign_flag    = flags_reg[FLG_S];
   assign carry_flag   = flags_reg[FLG_C];
   assign branch_taken = branch_reg;
   assign alu_a        = alu_a_reg;
   assign alu_b        = alu_b_reg;
   assign alu_ctrl     = alu_ctrl_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU and an op-level reference model.
module tb_alu_op_sequencer;

   logic        clka, rst, start;
   logic [3:0]  op;
   logic [2:0]  cond;
   logic [31:0] a, b;
   logic        ready, done, err, zero_flag, sign_flag, carry_flag, branch_taken;
   logic [31:0] result, alu_a, alu_b, alu_res;
   logic [4:0]  alu_ctrl;
   logic [2:0]  alu_flags;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] res, aa, bb;
      logic [4:0]  ctrl;
      logic [2:0]  flg;
      logic        br, err;
      int          acc, lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   // Reference state: stored flags {C,S,Z} and last values sent to the ALU
   logic [2:0]  m_flg;
   logic [31:0] m_aa, m_bb;
   logic [4:0]  m_ctrl;
   logic [4:0]  ctrl_tab [7] = '{5'b00000, 5'b10100, 5'b00001, 5'b00010,
                                 5'b00011, 5'b01011, 5'b01111};

   alu_op_sequencer dut (
      .clka(clka), .rst(rst), .start(start), .op(op), .cond(cond), .a(a), .b(b),
      .ready(ready), .done(done), .err(err), .result(result),
      .zero_flag(zero_flag), .sign_flag(sign_flag), .carry_flag(carry_flag),
      .branch_taken(branch_taken), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_res(alu_res), .alu_flags(alu_flags)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   always @(posedge clka) cyc <= cyc + 1;

   // Behavioural ALU decoding the control word; carry is registered on clka
   logic [31:0] tb_bb;
   logic [32:0] tb_sum;
   logic        alu_c_q = 1'b0;
   always_comb begin
      tb_bb  = alu_ctrl[4] ? ~alu_b : alu_b;
      tb_sum = {1'b0, alu_a} + {1'b0, tb_bb};
      case (alu_ctrl[1:0])
         2'b00:   alu_res = alu_a + tb_bb + {31'b0, alu_ctrl[2]};
         2'b01:   alu_res = alu_a & tb_bb;
         2'b10:   alu_res = alu_a ^ tb_bb;
         default: begin
            if (!alu_ctrl[3])    alu_res = alu_a << alu_b[4:0];
            else if (alu_ctrl[2]) alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            else                 alu_res = alu_a >> alu_b[4:0];
         end
      endcase
   end
   always @(posedge clka) alu_c_q <= tb_sum[32];
   assign alu_flags = {alu_c_q, alu_res[31], (alu_res == 32'd0)};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", nm, act, exp_v);
      end
   endtask

   function automatic logic branch_of(input logic [2:0] c, input logic [2:0] f);
      logic z, s, cy;
      z = f[0]; s = f[1]; cy = f[2];
      case (c)
         3'd0: return 1'b0;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return s;
         3'd4: return !s && !z;
         3'd5: return cy;
         3'd6: return !cy;
         default: return 1'b1;
      endcase
   endfunction

   // Reference model: op-level arithmetic, pushed into the scoreboard at accept time
   task automatic push_expect(input logic [3:0] o, input logic [2:0] c,
                              input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      logic [32:0] wide;
      logic        cy;
      e.op = o; e.acc = cyc;
      cy = 1'b0;
      if (o > 4'd6) begin
         e.res = 32'd0; e.br = 1'b0; e.err = 1'b1; e.lat = 1;
      end else begin
         case (o)
            4'd0: begin wide = {1'b0, x} + {1'b0, y}; e.res = wide[31:0]; cy = wide[32]; end
            4'd1: begin e.res = x - y; cy = (x > y); end
            4'd2: e.res = x & y;
            4'd3: e.res = x ^ y;
            4'd4: e.res = x << y[4:0];
            4'd5: e.res = x >> y[4:0];
            default: e.res = $unsigned($signed(x) >>> y[4:0]);
         endcase
         if (o <= 4'd1) m_flg = {cy, e.res[31], (e.res == 32'd0)};
         m_aa   = x;
         m_bb   = (o >= 4'd4) ? {27'd0, y[4:0]} : y;
         m_ctrl = ctrl_tab[o];
         e.br = branch_of(c, m_flg); e.err = 1'b0; e.lat = 3;
      end
      e.flg = m_flg; e.aa = m_aa; e.bb = m_bb; e.ctrl = m_ctrl;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic issue(input logic [3:0] o, input logic [2:0] c,
                        input logic [31:0] x, input logic [31:0] y, input bit keep);
      int n = 0;
      op = o; cond = c; a = x; b = y; start = 1'b1;
      while (!ready && n < 20) begin
         @(negedge clka);
         n++;
      end
      if (!ready) begin
         chk("ready_timeout", {31'd0, ready}, 32'd1);
         start = 1'b0;
         return;
      end
      push_expect(o, c, x, y);
      @(negedge clka);
      if (!keep) start = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"},  {31'd0, ready}, 32'd1);
      chk({tag, "_done"},   {31'd0, done}, 32'd0);
      chk({tag, "_err"},    {31'd0, err}, 32'd0);
      chk({tag, "_result"}, result, 32'd0);
      chk({tag, "_flags"},  {29'd0, carry_flag, sign_flag, zero_flag}, 32'd0);
      chk({tag, "_branch"}, {31'd0, branch_taken}, 32'd0);
      chk({tag, "_alu_a"},  alu_a, 32'd0);
      chk({tag, "_alu_b"},  alu_b, 32'd0);
      chk({tag, "_alu_ctrl"}, {27'd0, alu_ctrl}, 32'd0);
   endtask

   // Monitor: pops one expectation per done pulse
   always @(negedge clka) begin
      if (!rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("latency", cyc - mon_e.acc, mon_e.lat);
               chk("err", {31'd0, err}, {31'd0, mon_e.err});
               chk("result", result, mon_e.res);
               chk("flags", {29'd0, carry_flag, sign_flag, zero_flag}, {29'd0, mon_e.flg});
               chk("branch_taken", {31'd0, branch_taken}, {31'd0, mon_e.br});
               chk("alu_a", alu_a, mon_e.aa);
               chk("alu_b", alu_b, mon_e.bb);
               chk("alu_ctrl", {27'd0, alu_ctrl}, {27'd0, mon_e.ctrl});
               $display("txn op=%0d err=%0d result=%h zsc=%0d%0d%0d br=%0d ctrl=%b",
                        mon_e.op, err, result, zero_flag, sign_flag, carry_flag,
                        branch_taken, alu_ctrl);
            end
         end else if (sb.size() > 0 && cyc > sb[0].acc + 8) begin
            chk("done_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; op = 4'd0; cond = 3'd0; a = 32'd0; b = 32'd0;
      m_flg = 3'd0; m_aa = 32'd0; m_bb = 32'd0; m_ctrl = 5'd0;
      repeat (3) @(negedge clka);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clka);

      issue(4'd0, 3'd0, 32'd5, 32'd7, 1'b0);
      issue(4'd1, 3'd5, 32'd7, 32'd3, 1'b0);
      issue(4'd1, 3'd1, 32'd7, 32'd7, 1'b0);
      issue(4'd6, 3'd0, 32'h8000_0000, 32'h24, 1'b0);
      issue(4'hF, 3'd7, 32'd1, 32'd1, 1'b0);

      // Reset during CAPTURE of ADD 1+1 aborts the op with no done
      issue(4'd0, 3'd7, 32'd1, 32'd1, 1'b0);
      @(negedge clka);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midop_reset");
      sb.delete();
      m_flg = 3'd0; m_aa = 32'd0; m_bb = 32'd0; m_ctrl = 5'd0;
      @(negedge clka);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clka);
         chk("no_done_after_abort", {31'd0, done}, 32'd0);
      end
      issue(4'd0, 3'd2, 32'd2, 32'd2, 1'b0);

      // Start pulse during ISSUE must be ignored
      issue(4'd2, 3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
      op = 4'd2; a = 32'hFFFF_FFFF; b = 32'h1; start = 1'b1;
      @(negedge clka);
      start = 1'b0;
      repeat (4) @(negedge clka);

      for (int i = 0; i < 120; i++) begin
         logic [3:0]  ro;
         logic [31:0] ra, rb;
         ro = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
         ra = $urandom();
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = 32'($urandom_range(0, 40));
            default: rb = $urandom();
         endcase
         issue(ro, 3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
      end
      start = 1'b0;

      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clka);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
